rob_commit_unit: RTL and testbench
==================================

Name: rob_commit_unit

Overview:
- In-order reorder buffer and commit unit for the exec-stage result bus.
- Allocates a ROB tag per dispatched instruction, then absorbs out-of-order writebacks (result, dest reg, ctrl, tag) from the exec-stage arbiter.
- Retires entries in program order to the register file, with a store-commit pulse for the load/store queue.
- Sits between the exec stage and the register file / ld-st queue.

Parameters:
- ROB_SIZE, 4: tag width in bits; depth = 2^ROB_SIZE = 16 entries.
- DEST_REG_SIZE, 3: destination register index width.
- DATA_WIDTH, 32: result width.
- CTRL_WIDTH, 6: ctrl signal width carried from exec.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all entries
- alloc_req  in  1  dispatch requests a tag
- alloc_dest_reg  in  DEST_REG_SIZE  dest reg of dispatched instr
- alloc_is_store  in  1  dispatched instr is a store
- alloc_ready  out  1  an entry is available
- alloc_rob_entry  out  ROB_SIZE  tag granted (= tail pointer)
- wb_nop  in  1  high = no result on bus this cycle
- wb_rob_entry  in  ROB_SIZE  tag of completing instr
- wb_data  in  DATA_WIDTH  result
- wb_ctrl_sigs  in  CTRL_WIDTH  ctrl of completing instr
- commit_valid  out  1  registered commit strobe
- commit_dest_reg  out  DEST_REG_SIZE  register to write
- commit_data  out  DATA_WIDTH  value to write
- commit_ctrl_sigs  out  CTRL_WIDTH  ctrl of committed instr
- commit_rob_entry  out  ROB_SIZE  tag retired
- commit_store  out  1  one-cycle store commit pulse to ld-st queue
- rob_count  out  ROB_SIZE+1  occupied entries
- rob_empty  out  1  rob_count == 0

Behaviour:
- Reset: clock clk; reset is synchronous, active-high.
  - On reset, head = tail = count = 0 and all valid/done bits clear.
  - All commit_* outputs are 0; alloc_ready = 1; alloc_rob_entry = 0; rob_count = 0; rob_empty = 1.
- Reset asserted mid-operation discards every entry in the same edge.
- Allocate: on an edge with alloc_req && alloc_ready && !flush:
  - entry[tail] gets valid=1, done=0, dest, is_store.
  - tail increments modulo 2^ROB_SIZE.
  - alloc_rob_entry shows the current tail combinationally.
- alloc_ready = (count != 2^ROB_SIZE). There is no same-cycle bypass: when full, a commit in the same cycle does not permit an allocation.
- Writeback: on an edge with !wb_nop && !flush and entry[wb_rob_entry].valid && !done:
  - data and ctrl are stored; done=1.
  - A writeback to an invalid or already-done entry is ignored.
- Commit: on an edge where entry[head].valid && done && !flush:
  - commit_* registers load from entry[head]; commit_valid=1.
  - commit_store = is_store.
  - entry[head].valid cleared; head increments modulo 2^ROB_SIZE.
  - Otherwise commit_valid=0 and commit_store=0; other commit_* hold their values.
- Maximum one commit per cycle; there is no backpressure on commit.
- Latency: a writeback sampled at edge k to the head entry gives commit_valid high for the cycle after edge k+1. There is no writeback-to-commit bypass.
- Simultaneous events:
  - Alloc, writeback and commit may all occur on one edge.
  - count' = count + alloc − commit.
  - A writeback targeting the head entry on the same edge does not commit on that edge.
- Flush has priority over alloc, writeback and commit. It clears all valid bits; head = tail = count = 0; commit_valid = commit_store = 0 on the next cycle.
- Wrap-around: pointers wrap from 2^ROB_SIZE−1 to 0 with no gap. Full and empty are distinguished by count, not by pointer equality.

Optional Feature:
- Macro ROB_WB_CHECK_EN.
- Defined: adds output wb_err (1 bit, sticky, reset/flush → 0). It is set on any writeback (!wb_nop) to an entry that is not valid, or is already done. The ignore semantics are unchanged.
- Undefined: no wb_err port; bad writebacks are silently ignored.

Decomposition:
- Shared package holds:
  - ROB_SIZE, DEST_REG_SIZE, DATA_WIDTH, CTRL_WIDTH defaults (shared with exec_stage);
  - the ROB entry struct {valid, done, is_store, dest, ctrl, data};
  - the ROB_DEPTH constant.
- One natural sub-module: rob_ptr_ctrl (head/tail/count update, full/empty, flush/reset priority). The entry array and commit registers stay in the top.

Test Plan:
- Reset, then alloc 3 (dest 1,2,3); writeback tags 2,1,0 with data 0x30,0x20,0x10 on consecutive cycles → commits in order: (tag0, r1, 0x10), (tag1, r2, 0x20), (tag2, r3, 0x30) on consecutive cycles, with the first commit 2 cycles after the tag-0 writeback.
- Alloc 16 with no writeback → alloc_ready=0, rob_count=16. Hold alloc_req high, then writeback tag0 → tag0 commits; alloc_ready rises the cycle after the commit, next tag granted = 0 (wrap).
- Alloc store at tag 0, writeback tag 0 → commit_valid=1 and commit_store=1 for exactly one cycle; a non-store commit follows with commit_store=0.
- 5 entries outstanding with 2 done, assert flush together with alloc_req and a writeback → next cycle rob_count=0, rob_empty=1, commit_valid=0, next alloc_rob_entry=0.
- Writeback to an unallocated tag 7 with data 0xDEAD → no commit and no state change; with ROB_WB_CHECK_EN, wb_err=1 until reset.
- Assert reset with 4 entries, 2 done → next cycle all outputs at reset values, and no commit for the old entries ever appears.

Source files
------------

// File: rtl/rob_commit_unit_pkg.sv
// Shared sizing and ROB entry layout for rob_commit_unit and the exec stage.
package rob_commit_unit_pkg;

    localparam int ROB_SIZE      = 4;
    localparam int DEST_REG_SIZE = 3;
    localparam int DATA_WIDTH    = 32;
    localparam int CTRL_WIDTH    = 6;
    localparam int ROB_DEPTH     = 1 << ROB_SIZE;

    typedef struct packed {
        logic                     valid;
        logic                     done;
        logic                     is_store;
        logic [DEST_REG_SIZE-1:0] dest;
        logic [CTRL_WIDTH-1:0]    ctrl;
        logic [DATA_WIDTH-1:0]    data;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy tracking for the ROB. Reset and flush both return the
// pointers to zero and take priority over allocation and commit. Full and
// empty come from the occupancy count, so head == tail is never ambiguous.
module rob_ptr_ctrl
    import rob_commit_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                alloc_req,
    input  logic                do_commit,
    output logic                do_alloc,
    output logic [ROB_SIZE-1:0] head,
    output logic [ROB_SIZE-1:0] tail,
    output logic [ROB_SIZE:0]   count,
    output logic                alloc_ready,
    output logic                rob_empty
);

    // Full is judged on the registered count only; a commit on the same edge
    // does not free a slot for an allocation on that edge.
    always_comb begin
        alloc_ready = (count != (ROB_SIZE+1)'(ROB_DEPTH));
        rob_empty   = (count == '0);
        do_alloc    = alloc_req && alloc_ready && !flush;
    end

    // Pointer and count update; the pointers wrap naturally at ROB_DEPTH.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_alloc)
                tail <= tail + ROB_SIZE'(1);
            if (do_commit)
                head <= head + ROB_SIZE'(1);
            count <= count + (ROB_SIZE+1)'(do_alloc) - (ROB_SIZE+1)'(do_commit);
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer and commit unit. Tags are granted at dispatch,
// results arrive out of order from the exec-stage bus, and entries retire in
// program order through registered commit outputs (one per cycle).
// Optional build macro ROB_WB_CHECK_EN adds a sticky wb_err output that flags
// writebacks to entries that are not valid or already done.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     alloc_req,
    input  logic [DEST_REG_SIZE-1:0] alloc_dest_reg,
    input  logic                     alloc_is_store,
    output logic                     alloc_ready,
    output logic [ROB_SIZE-1:0]      alloc_rob_entry,
    input  logic                     wb_nop,
    input  logic [ROB_SIZE-1:0]      wb_rob_entry,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic [CTRL_WIDTH-1:0]    wb_ctrl_sigs,
    output logic                     commit_valid,
    output logic [DEST_REG_SIZE-1:0] commit_dest_reg,
    output logic [DATA_WIDTH-1:0]    commit_data,
    output logic [CTRL_WIDTH-1:0]    commit_ctrl_sigs,
    output logic [ROB_SIZE-1:0]      commit_rob_entry,
    output logic                     commit_store,
    output logic [ROB_SIZE:0]        rob_count,
    output logic                     rob_empty
`ifdef ROB_WB_CHECK_EN
    ,
    output logic                     wb_err
`endif
);

    rob_entry_t          entries [ROB_DEPTH];
    rob_entry_t          head_entry;
    rob_entry_t          wb_entry;
    logic [ROB_SIZE-1:0] head;
    logic [ROB_SIZE-1:0] tail;
    logic                do_alloc;
    logic                do_commit;
    logic                wb_hit;

    rob_ptr_ctrl u_ptr_ctrl (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .alloc_req   (alloc_req),
        .do_commit   (do_commit),
        .do_alloc    (do_alloc),
        .head        (head),
        .tail        (tail),
        .count       (rob_count),
        .alloc_ready (alloc_ready),
        .rob_empty   (rob_empty)
    );

    // Head retires once its result is in; a writeback lands one edge before
    // it can commit, since done is read from the registered entry.
    always_comb begin
        head_entry      = entries[head];
        wb_entry        = entries[wb_rob_entry];
        alloc_rob_entry = tail;
        do_commit       = head_entry.valid && head_entry.done && !flush;
        wb_hit          = !wb_nop && !flush && wb_entry.valid && !wb_entry.done;
    end

    // Entry array: allocate at tail, absorb writebacks, release head on commit.
    // The three never target the same slot on one edge (full blocks alloc,
    // done separates writeback from commit, empty blocks commit).
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
        end else begin
            if (do_alloc) begin
                entries[tail].valid    <= 1'b1;
                entries[tail].done     <= 1'b0;
                entries[tail].is_store <= alloc_is_store;
                entries[tail].dest     <= alloc_dest_reg;
            end
            if (wb_hit) begin
                entries[wb_rob_entry].data <= wb_data;
                entries[wb_rob_entry].ctrl <= wb_ctrl_sigs;
                entries[wb_rob_entry].done <= 1'b1;
            end
            if (do_commit)
                entries[head].valid <= 1'b0;
        end
    end

    // Commit registers: strobes pulse per retirement, payload holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_valid     <= 1'b0;
            commit_store     <= 1'b0;
            commit_dest_reg  <= '0;
            commit_data      <= '0;
            commit_ctrl_sigs <= '0;
            commit_rob_entry <= '0;
        end else if (do_commit) begin
            commit_valid     <= 1'b1;
            commit_store     <= head_entry.is_store;
            commit_dest_reg  <= head_entry.dest;
            commit_data      <= head_entry.data;
            commit_ctrl_sigs <= head_entry.ctrl;
            commit_rob_entry <= head;
        end else begin
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
        end
    end

`ifdef ROB_WB_CHECK_EN
    // Sticky flag for writebacks that the array ignores.
    always_ff @(posedge clk) begin
        if (reset || flush)
            wb_err <= 1'b0;
        else if (!wb_nop && !(wb_entry.valid && !wb_entry.done))
            wb_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: a program-order tag queue is filled at dispatch
// and drained by a monitor that checks every commit against the bench model.
module tb_rob_commit_unit;
    import rob_commit_unit_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic                     alloc_req;
    logic [DEST_REG_SIZE-1:0] alloc_dest_reg;
    logic                     alloc_is_store;
    logic                     alloc_ready;
    logic [ROB_SIZE-1:0]      alloc_rob_entry;
    logic                     wb_nop;
    logic [ROB_SIZE-1:0]      wb_rob_entry;
    logic [DATA_WIDTH-1:0]    wb_data;
    logic [CTRL_WIDTH-1:0]    wb_ctrl_sigs;
    logic                     commit_valid;
    logic [DEST_REG_SIZE-1:0] commit_dest_reg;
    logic [DATA_WIDTH-1:0]    commit_data;
    logic [CTRL_WIDTH-1:0]    commit_ctrl_sigs;
    logic [ROB_SIZE-1:0]      commit_rob_entry;
    logic                     commit_store;
    logic [ROB_SIZE:0]        rob_count;
    logic                     rob_empty;
`ifdef ROB_WB_CHECK_EN
    logic                     wb_err;
`endif

    rob_commit_unit dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .alloc_req        (alloc_req),
        .alloc_dest_reg   (alloc_dest_reg),
        .alloc_is_store   (alloc_is_store),
        .alloc_ready      (alloc_ready),
        .alloc_rob_entry  (alloc_rob_entry),
        .wb_nop           (wb_nop),
        .wb_rob_entry     (wb_rob_entry),
        .wb_data          (wb_data),
        .wb_ctrl_sigs     (wb_ctrl_sigs),
        .commit_valid     (commit_valid),
        .commit_dest_reg  (commit_dest_reg),
        .commit_data      (commit_data),
        .commit_ctrl_sigs (commit_ctrl_sigs),
        .commit_rob_entry (commit_rob_entry),
        .commit_store     (commit_store),
        .rob_count        (rob_count),
        .rob_empty        (rob_empty)
`ifdef ROB_WB_CHECK_EN
        ,
        .wb_err           (wb_err)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit mon_en  = 1'b0;

    logic [ROB_SIZE-1:0]      tagq [$];
    logic [ROB_SIZE-1:0]      m_tail;
    logic [DEST_REG_SIZE-1:0] m_dest  [ROB_DEPTH];
    logic                     m_store [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]    m_data  [ROB_DEPTH];
    logic [CTRL_WIDTH-1:0]    m_ctrl  [ROB_DEPTH];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        tagq.delete();
        m_tail = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic do_alloc(input logic [DEST_REG_SIZE-1:0] d, input logic st);
        chk("alloc_ready", alloc_ready, 1);
        chk("alloc_tag", alloc_rob_entry, m_tail);
        alloc_req      = 1'b1;
        alloc_dest_reg = d;
        alloc_is_store = st;
        step();
        alloc_req = 1'b0;
        m_dest[m_tail]  = d;
        m_store[m_tail] = st;
        tagq.push_back(m_tail);
        m_tail = m_tail + 1'b1;
    endtask

    // good=0 marks a writeback the DUT must ignore; the model keeps its data.
    task automatic do_wb(input logic [ROB_SIZE-1:0] t, input logic [DATA_WIDTH-1:0] d,
                         input logic [CTRL_WIDTH-1:0] c, input bit good);
        wb_nop       = 1'b0;
        wb_rob_entry = t;
        wb_data      = d;
        wb_ctrl_sigs = c;
        if (good) begin
            m_data[t] = d;
            m_ctrl[t] = c;
        end
        step();
        wb_nop = 1'b1;
    endtask

    // Scoreboard: each commit must be the oldest outstanding tag with its payload.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (commit_valid === 1'b1) begin
                if (tagq.size() == 0) begin
                    chk("spurious_commit", {60'd0, commit_rob_entry}, 64'hFFFF);
                end else begin
                    logic [ROB_SIZE-1:0] t;
                    t = tagq.pop_front();
                    chk("commit_tag",   commit_rob_entry, t);
                    chk("commit_dest",  commit_dest_reg,  m_dest[t]);
                    chk("commit_data",  commit_data,      m_data[t]);
                    chk("commit_ctrl",  commit_ctrl_sigs, m_ctrl[t]);
                    chk("commit_store", commit_store,     m_store[t]);
                end
            end else begin
                chk("idle_store", commit_store, 0);
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; alloc_req = 1'b0; alloc_dest_reg = '0;
        alloc_is_store = 1'b0; wb_nop = 1'b1; wb_rob_entry = '0; wb_data = '0;
        wb_ctrl_sigs = '0;
        model_clear();
        step(); step();
        reset = 1'b0;
        mon_en = 1'b1;

        // reset values
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_store", commit_store, 0);
        chk("rst_commit_dest",  commit_dest_reg, 0);
        chk("rst_commit_data",  commit_data, 0);
        chk("rst_commit_ctrl",  commit_ctrl_sigs, 0);
        chk("rst_commit_tag",   commit_rob_entry, 0);
        chk("rst_alloc_ready",  alloc_ready, 1);
        chk("rst_alloc_tag",    alloc_rob_entry, 0);
        chk("rst_count",        rob_count, 0);
        chk("rst_empty",        rob_empty, 1);
`ifdef ROB_WB_CHECK_EN
        chk("rst_wb_err", wb_err, 0);
`endif

        // in-order retirement of out-of-order writebacks
        do_alloc(3'd1, 1'b0);
        do_alloc(3'd2, 1'b0);
        do_alloc(3'd3, 1'b0);
        chk("t1_count", rob_count, 3);
        chk("t1_empty", rob_empty, 0);
        do_wb(4'd2, 32'h30, 6'h03, 1'b1);
        do_wb(4'd1, 32'h20, 6'h02, 1'b1);
        do_wb(4'd0, 32'h10, 6'h01, 1'b1);
        chk("t1_no_bypass", commit_valid, 0);
        step();
        chk("t1_c0_valid", commit_valid, 1);
        chk("t1_c0_tag", commit_rob_entry, 0);
        step();
        chk("t1_c1_valid", commit_valid, 1);
        chk("t1_c1_tag", commit_rob_entry, 1);
        step();
        chk("t1_c2_valid", commit_valid, 1);
        chk("t1_c2_tag", commit_rob_entry, 2);
        step();
        chk("t1_drain_valid", commit_valid, 0);
        chk("t1_drain_q", tagq.size(), 0);
        chk("t1_empty_end", rob_empty, 1);
        chk("t1_hold_data", commit_data, 32'h30);

        // full ROB, commit frees a slot the following cycle, tag wraps to 0
        do_reset();
        for (int i = 0; i < ROB_DEPTH; i++)
            do_alloc(DEST_REG_SIZE'(i), 1'b0);
        chk("t2_full_ready", alloc_ready, 0);
        chk("t2_full_count", rob_count, 16);
        alloc_req = 1'b1; alloc_dest_reg = 3'd5; alloc_is_store = 1'b0;
        do_wb(4'd0, 32'hAA, 6'h15, 1'b1);
        chk("t2_still_full", alloc_ready, 0);
        chk("t2_count16", rob_count, 16);
        step();
        chk("t2_commit_valid", commit_valid, 1);
        chk("t2_commit_tag", commit_rob_entry, 0);
        chk("t2_ready_rise", alloc_ready, 1);
        chk("t2_count15", rob_count, 15);
        chk("t2_wrap_tag", alloc_rob_entry, 0);
        step();
        alloc_req = 1'b0;
        m_dest[0] = 3'd5; m_store[0] = 1'b0;
        tagq.push_back(4'd0);
        m_tail = m_tail + 1'b1;
        chk("t2_refull_count", rob_count, 16);
        chk("t2_refull_ready", alloc_ready, 0);

        // store commit pulse
        do_reset();
        do_alloc(3'd4, 1'b1);
        do_alloc(3'd6, 1'b0);
        do_wb(4'd0, 32'h55, 6'h2A, 1'b1);
        do_wb(4'd1, 32'h66, 6'h11, 1'b1);
        chk("t3_st_valid", commit_valid, 1);
        chk("t3_st_pulse", commit_store, 1);
        step();
        chk("t3_ld_valid", commit_valid, 1);
        chk("t3_ld_store", commit_store, 0);
        step();
        chk("t3_idle_valid", commit_valid, 0);
        chk("t3_idle_store", commit_store, 0);

        // flush beats simultaneous alloc and writeback
        do_reset();
        for (int i = 0; i < 5; i++)
            do_alloc(DEST_REG_SIZE'(i + 1), 1'b0);
        do_wb(4'd2, 32'h222, 6'h02, 1'b1);
        do_wb(4'd3, 32'h333, 6'h03, 1'b1);
        flush = 1'b1; alloc_req = 1'b1; alloc_dest_reg = 3'd7;
        wb_nop = 1'b0; wb_rob_entry = 4'd4; wb_data = 32'h444; wb_ctrl_sigs = 6'h04;
        step();
        flush = 1'b0; alloc_req = 1'b0; wb_nop = 1'b1;
        model_clear();
        chk("t4_count", rob_count, 0);
        chk("t4_empty", rob_empty, 1);
        chk("t4_commit_valid", commit_valid, 0);
        chk("t4_alloc_tag", alloc_rob_entry, 0);
        for (int i = 0; i < 4; i++) step();
        do_alloc(3'd3, 1'b1);
        do_wb(4'd0, 32'h1234, 6'h2B, 1'b1);
        step();
        chk("t4_recover_valid", commit_valid, 1);
        chk("t4_recover_store", commit_store, 1);
        step();
        chk("t4_drain_q", tagq.size(), 0);

        // ignored writebacks: unallocated tag, then already-done entry
        do_reset();
        do_alloc(3'd2, 1'b0);
        do_wb(4'd7, 32'hDEAD, 6'h3F, 1'b0);
        step();
        chk("t5_count", rob_count, 1);
        chk("t5_no_commit", commit_valid, 0);
        chk("t5_alloc_tag", alloc_rob_entry, 1);
`ifdef ROB_WB_CHECK_EN
        chk("t5_wb_err_set", wb_err, 1);
`endif
        do_wb(4'd0, 32'hBEEF, 6'h0C, 1'b1);
        do_wb(4'd0, 32'hBAD0, 6'h3C, 1'b0);
        chk("t5_commit_valid", commit_valid, 1);
        step();
        chk("t5_drain_q", tagq.size(), 0);
`ifdef ROB_WB_CHECK_EN
        chk("t5_wb_err_sticky", wb_err, 1);
        do_reset();
        chk("t5_wb_err_clr", wb_err, 0);
`endif

        // reset mid-operation beats a commit due on the same edge
        do_reset();
        for (int i = 0; i < 4; i++)
            do_alloc(DEST_REG_SIZE'(i + 4), 1'b0);
        do_wb(4'd1, 32'h101, 6'h01, 1'b1);
        do_wb(4'd0, 32'h100, 6'h00, 1'b1);
        do_reset();
        chk("t6_commit_valid", commit_valid, 0);
        chk("t6_commit_store", commit_store, 0);
        chk("t6_commit_dest",  commit_dest_reg, 0);
        chk("t6_commit_data",  commit_data, 0);
        chk("t6_commit_ctrl",  commit_ctrl_sigs, 0);
        chk("t6_commit_tag",   commit_rob_entry, 0);
        chk("t6_alloc_ready",  alloc_ready, 1);
        chk("t6_alloc_tag",    alloc_rob_entry, 0);
        chk("t6_count",        rob_count, 0);
        chk("t6_empty",        rob_empty, 1);
        for (int i = 0; i < 20; i++) step();
        chk("t6_end_empty", rob_empty, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
